// File: rtl/heaa_pkg.sv
// Shared types and helpers for the HEAA error-statistics monitor.
// Holds default widths, FSM states and the ED magnitude helper.
package heaa_pkg;

  localparam int HEAA_WIDTH = 32;
  localparam int HEAA_INACC = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [HEAA_WIDTH:0] abs_diff(
    input logic [HEAA_WIDTH:0] x,
    input logic [HEAA_WIDTH:0] y
  );
    return (x >= y) ? x - y : y - x;
  endfunction

endpackage

// File: rtl/heaa_ref_model.sv
// Combinational HEAA approximate adder used as an internal sum source.
// Low INACC bits are approximated; the upper slice is added exactly.
module heaa_ref_model
  import heaa_pkg::*;
#(
  parameter int WIDTH = HEAA_WIDTH,
  parameter int INACC = HEAA_INACC
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum_apx
);

  logic cin;

  assign cin = a[INACC-1] & b[INACC-1];

  assign sum_apx[INACC-2:0] =
    a[INACC-2:0] | b[INACC-2:0];
  assign sum_apx[INACC-1] =
    a[INACC-1] ^ b[INACC-1];

  if (INACC < WIDTH) begin : g_upper
    assign sum_apx[WIDTH:INACC] =
      {1'b0, a[WIDTH-1:INACC]}
      + {1'b0, b[WIDTH-1:INACC]}
      + (WIDTH-INACC+1)'(cin);
  end else begin : g_carry_only
    assign sum_apx[WIDTH] = cin;
  end

endmodule

// File: rtl/heaa_err_monitor.sv
// Two-stage ED measurement sink with windowed error statistics.
// Define HEAA_REF_MODEL_EN to derive sum_apx internally from a and b.
module heaa_err_monitor
  import heaa_pkg::*;
#(
  parameter int WIDTH = HEAA_WIDTH,
  parameter int INACC = HEAA_INACC,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] window_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   sum_apx,
  output logic             ed_valid,
  output logic [WIDTH:0]   ed_out,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] sum_ed
);

  if (INACC < 2 || INACC > WIDTH) begin : g_bad_inacc
    $error("heaa_err_monitor: INACC out of range");
  end

  state_t           state;
  state_t           nstate;
  logic [CNT_W-1:0] win_len;
  logic [CNT_W-1:0] win_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] acc_nxt;
  logic             go;
  logic             accept;
  logic             last;
  logic             ready_nxt;
  logic [WIDTH:0]   apx;
  logic [WIDTH:0]   exact;
  logic [WIDTH:0]   ed_nxt;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] sum_nxt;

`ifdef HEAA_REF_MODEL_EN
  heaa_ref_model #(
    .WIDTH (WIDTH),
    .INACC (INACC)
  ) u_ref (
    .a       (a),
    .b       (b),
    .sum_apx (apx)
  );
`else
  assign apx = sum_apx;
`endif

  assign exact = {1'b0, a} + {1'b0, b};

  if (WIDTH == HEAA_WIDTH) begin : g_pkg_diff
    assign ed_nxt = abs_diff(exact, apx);
  end else begin : g_local_diff
    assign ed_nxt = (exact >= apx) ? exact - apx
                                   : apx - exact;
  end

  // A window only opens outside RUN and never with a zero length
  assign go = start && !clear
           && (window_len != '0)
           && (state != RUN);
  assign accept = in_valid && in_ready;
  assign last = ed_valid
             && (sample_cnt + CNT_W'(1) == win_len);

  assign win_nxt = go ? window_len : win_len;
  assign acc_nxt = go ? '0
                      : acc_cnt + CNT_W'(accept);
  assign ready_nxt = (nstate == RUN)
                  && (acc_nxt < win_nxt);

  assign acc_sum = {1'b0, sum_ed}
                 + (ACC_W+1)'(ed_out);
  assign sum_nxt = acc_sum[ACC_W] ? '1
                                  : acc_sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (clear) begin
      nstate = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (go)   nstate = RUN;
        RUN:     if (last) nstate = DONE;
        DONE:    if (go)   nstate = RUN;
        default:           nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_len    <= '0;
      acc_cnt    <= '0;
      in_ready   <= 1'b0;
      ed_valid   <= 1'b0;
      ed_out     <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else if (clear) begin
      acc_cnt    <= '0;
      in_ready   <= 1'b0;
      ed_valid   <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else begin
      win_len  <= win_nxt;
      acc_cnt  <= acc_nxt;
      in_ready <= ready_nxt;
      ed_valid <= accept;
      if (accept) ed_out <= ed_nxt;
      if (go) begin
        sample_cnt <= '0;
        err_cnt    <= '0;
        max_ed     <= '0;
        sum_ed     <= '0;
      end else if (ed_valid) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_cnt    <= err_cnt
                    + CNT_W'(ed_out != '0);
        if (ed_out > max_ed) max_ed <= ed_out;
        sum_ed     <= sum_nxt;
      end
    end
  end

endmodule

// File: tb/tb_heaa_err_monitor.sv
// Randomised bench for heaa_err_monitor against a queue-based model.
// Follows HEAA_REF_MODEL_EN the same way the design does.
module tb_heaa_err_monitor;

  localparam int W     = 32;
  localparam int INACC = 11;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;
  localparam longint unsigned MAXACC = 64'hFFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] window_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic [W:0]       sum_apx = '0;
  logic             ed_valid;
  logic [W:0]       ed_out;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [W:0]       max_ed;
  logic [ACC_W-1:0] sum_ed;

  heaa_err_monitor #(
    .WIDTH (W),
    .INACC (INACC),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .window_len (window_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sum_apx    (sum_apx),
    .ed_valid   (ed_valid),
    .ed_out     (ed_out),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .max_ed     (max_ed),
    .sum_ed     (sum_ed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int                cyc = 0;
  bit                active = 0;
  longint unsigned   mlen = 0;
  longint unsigned   q_ed[$];
  int                q_cyc[$];
  int                cidx = 0;
  longint unsigned   m_cnt = 0;
  longint unsigned   m_err = 0;
  longint unsigned   m_max = 0;
  longint unsigned   m_sum = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

`ifdef HEAA_REF_MODEL_EN
  function automatic longint unsigned ref_apx(
    input longint unsigned x,
    input longint unsigned y);
    longint unsigned lowm = (64'd1 << (INACC-1)) - 1;
    longint unsigned lo   = (x | y) & lowm;
    longint unsigned mid  = ((x ^ y) >> (INACC-1)) & 1;
    longint unsigned c    = (x >> (INACC-1)) & (y >> (INACC-1)) & 1;
    longint unsigned hi   = (x >> INACC) + (y >> INACC) + c;
    return lo | (mid << (INACC-1)) | (hi << INACC);
  endfunction
`endif

  function automatic longint unsigned model_ed(
    input longint unsigned x,
    input longint unsigned y,
    input longint unsigned apx_in);
    longint unsigned ex = x + y;
    longint unsigned ap = apx_in;
`ifdef HEAA_REF_MODEL_EN
    ap = ref_apx(x, y);
`endif
    return (ex > ap) ? ex - ap : ap - ex;
  endfunction

  function automatic bit m_done();
    return active && (q_ed.size() == mlen)
        && (q_cyc[q_cyc.size()-1] <= cyc - 2);
  endfunction

  function automatic bit m_ready();
    return active && (q_ed.size() < mlen);
  endfunction

  task automatic model_clear();
    q_ed.delete();
    q_cyc.delete();
    cidx   = 0;
    active = 0;
    m_cnt  = 0;
    m_err  = 0;
    m_max  = 0;
    m_sum  = 0;
  endtask

  task automatic check_all();
    bit exp_v;
    exp_v = (q_ed.size() > 0)
         && (q_cyc[q_cyc.size()-1] == cyc - 1);
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("ed_valid", 64'(ed_valid), 64'(exp_v));
    if (exp_v)
      chk("ed_out", 64'(ed_out), q_ed[q_ed.size()-1]);
    chk("done", 64'(done), 64'(m_done()));
    chk("sample_cnt", 64'(sample_cnt), m_cnt);
    chk("err_cnt", 64'(err_cnt), m_err);
    chk("max_ed", 64'(max_ed), m_max);
    chk("sum_ed", 64'(sum_ed), m_sum);
  endtask

  task automatic tick(input bit iv,
                      input logic [W-1:0] ta,
                      input logic [W-1:0] tb,
                      input logic [W:0] tapx,
                      input bit st,
                      input bit cl,
                      input logic [CNT_W-1:0] len);
    bit acc;
    bit st_ok;
    longint unsigned e;
    in_valid   = iv;
    a          = ta;
    b          = tb;
    sum_apx    = tapx;
    start      = st;
    clear      = cl;
    window_len = len;
    acc   = iv && m_ready() && !cl;
    st_ok = st && !cl && (len != 0)
         && (!active || m_done());
    e = model_ed(64'(ta), 64'(tb), 64'(tapx));
    @(posedge clk);
    #1;
    if (cl) begin
      model_clear();
    end else if (st_ok) begin
      model_clear();
      active = 1;
      mlen   = 64'(len);
    end else if (acc) begin
      q_ed.push_back(e);
      q_cyc.push_back(cyc);
    end
    cyc++;
    while (cidx < q_ed.size() && q_cyc[cidx] <= cyc - 2) begin
      e = q_ed[cidx];
      m_cnt++;
      if (e != 0) m_err++;
      if (e > m_max) m_max = e;
      m_sum = (m_sum + e > MAXACC) ? MAXACC : m_sum + e;
      cidx++;
    end
    check_all();
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(0, '0, '0, '0, 0, 0, '0);
  endtask

  task automatic rand_sample(input bit iv,
                             input bit st,
                             input bit cl,
                             input logic [CNT_W-1:0] len);
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   ex;
    logic [W:0]   rp;
    ra = $urandom;
    rb = $urandom;
    ex = {1'b0, ra} + {1'b0, rb};
    case ($urandom_range(0, 3))
      0: rp = ex;
      1: rp = ex + (W+1)'($urandom_range(1, 100));
      2: rp = ex - (W+1)'($urandom_range(1, 100));
      default: begin
        rp[W-1:0] = $urandom;
        rp[W]     = 1'($urandom_range(0, 1));
      end
    endcase
    tick(iv, ra, rb, rp, st, cl, len);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_in_ready"}, 64'(in_ready), 0);
    chk({pfx, "_ed_valid"}, 64'(ed_valid), 0);
    chk({pfx, "_ed_out"}, 64'(ed_out), 0);
    chk({pfx, "_done"}, 64'(done), 0);
    chk({pfx, "_sample_cnt"}, 64'(sample_cnt), 0);
    chk({pfx, "_err_cnt"}, 64'(err_cnt), 0);
    chk({pfx, "_max_ed"}, 64'(max_ed), 0);
    chk({pfx, "_sum_ed"}, 64'(sum_ed), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // zero-length start is ignored in IDLE
    tick(0, '0, '0, '0, 1, 0, '0);
    idle(2);

    // directed samples
    tick(0, '0, '0, '0, 1, 0, 32'd2);
`ifdef HEAA_REF_MODEL_EN
    tick(1, 32'h3FF, 32'h3FF, '0, 0, 0, '0);
    chk("dir_ed0", 64'(ed_out), 64'h3FF);
    tick(1, 32'h3FF, 32'h1, '0, 0, 0, '0);
    chk("dir_ed1", 64'(ed_out), 64'h1);
    idle(3);
    chk("dir_max", 64'(max_ed), 64'h3FF);
    chk("dir_sum", 64'(sum_ed), 64'h400);
    chk("dir_err", 64'(err_cnt), 2);
`else
    tick(1, 32'd3, 32'd1, 33'd3, 0, 0, '0);
    chk("dir_ed0", 64'(ed_out), 1);
    tick(1, 32'h400, 32'h400, 33'h800, 0, 0, '0);
    chk("dir_ed1", 64'(ed_out), 0);
    idle(3);
    chk("dir_max", 64'(max_ed), 1);
    chk("dir_sum", 64'(sum_ed), 1);
    chk("dir_err", 64'(err_cnt), 1);
`endif
    chk("dir_cnt", 64'(sample_cnt), 2);
    chk("dir_done", 64'(done), 1);

    // zero-length start in DONE keeps the frozen stats
    tick(0, '0, '0, '0, 1, 0, '0);
    chk("len0_done", 64'(done), 1);
    idle(1);

    // window of 4 with in_valid held high
    tick(0, '0, '0, '0, 1, 0, 32'd4);
    for (int i = 0; i < 8; i++) rand_sample(1, 0, 0, '0);
    chk("w4_cnt", 64'(sample_cnt), 4);
    chk("w4_done", 64'(done), 1);

    // clear together with start while samples are in flight
    tick(0, '0, '0, '0, 1, 0, 32'd8);
    rand_sample(1, 0, 0, '0);
    rand_sample(1, 0, 0, '0);
    rand_sample(1, 1, 1, 32'd8);
    chk("clr_cnt", 64'(sample_cnt), 0);
    chk("clr_edv", 64'(ed_valid), 0);
    chk("clr_rdy", 64'(in_ready), 0);
    idle(3);

    // randomised windows with stray starts and rare clears
    for (int w = 0; w < 30; w++) begin
      tick(0, '0, '0, '0, 1, 0,
           CNT_W'($urandom_range(1, 10)));
      for (int i = 0; i < 60; i++) begin
        rand_sample($urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 39) == 0,
                    CNT_W'($urandom_range(0, 5)));
        if (!active || m_done()) break;
      end
      chk("win_end", 64'(active && !m_done()), 0);
      idle(2);
    end

    // saturation of the summed ED
    tick(0, '0, '0, '0, 1, 0, 32'd32770);
    for (int i = 0; i < 32772; i++)
      tick(1, '0, '0, 33'h1_FFFF_FFFF, 0, 0, '0);
    chk("sat_done", 64'(done), 1);
`ifndef HEAA_REF_MODEL_EN
    chk("sat_sum", 64'(sum_ed), MAXACC);
    chk("sat_max", 64'(max_ed), 64'h1_FFFF_FFFF);
`endif

    // asynchronous reset in the middle of a window
    tick(0, '0, '0, '0, 1, 0, 32'd10);
    for (int i = 0; i < 3; i++) rand_sample(1, 0, 0, '0);
    rst = 1'b1;
    #1;
    check_zero("arst");
    model_clear();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;

    // recovery after reset
    tick(0, '0, '0, '0, 1, 0, 32'd5);
    for (int i = 0; i < 12; i++)
      rand_sample($urandom_range(0, 1) == 1, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/heaa_err_monitor.md
Name: heaa_err_monitor

Overview:
- Pipelined error-measurement sink for the HEAA approximate adder family. It consumes operand pairs and an approximate sum.
- Per sample, it computes the exact sum and the error distance ED = |exact − approximate|.
- Over a programmed window of samples, it accumulates sample count, error count, max ED and summed ED.
- Sits downstream of heaa_* adders in characterisation benches and silicon self-test; it is the consumer of adder results.

Parameters:
- WIDTH, 32, operand width; sums are WIDTH+1 bits.
- INACC, 11, number of inexact low bits of the modelled adder; legal range 2..WIDTH.
- CNT_W, 32, width of the sample and error counters.
- ACC_W, 48, width of the summed-ED accumulator.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begin a window (accepted in IDLE or DONE).
- clear  in  1  pulse; zero statistics, return to IDLE.
- window_len  in  CNT_W  samples per window; sampled on start.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sum_apx  in  WIDTH+1  approximate sum under test.
- ed_valid  out  1  per-sample ED valid (one-cycle pulse).
- ed_out  out  WIDTH+1  per-sample error distance.
- done  out  1  window complete; statistics frozen.
- sample_cnt  out  CNT_W  samples accumulated.
- err_cnt  out  CNT_W  samples with ED != 0.
- max_ed  out  WIDTH+1  maximum ED in the window.
- sum_ed  out  ACC_W  summed ED, saturating.

Behaviour:
- Reset: the following are all 0 and the state is IDLE: in_ready, ed_valid, ed_out, done, sample_cnt, err_cnt, max_ed, sum_ed, and the internal accept counter.
- FSM states:
  - IDLE: start → RUN; latch window_len; zero statistics and accept counter.
  - RUN: in_ready = (accept_cnt < window_len). After the stats update for the window_len-th sample → DONE.
  - DONE: done=1; outputs hold; start → RUN with the same restart actions as from IDLE.
- clear in any state → IDLE with statistics zeroed. clear and start in the same cycle: clear wins.
- start in RUN is ignored.
- window_len = 0: the start is ignored and the FSM stays in its current state (IDLE or DONE).
- Handshake:
  - Accept when in_valid && in_ready; accept_cnt increments.
  - in_ready is registered.
  - No sample is accepted beyond window_len.
- Stage 1 (cycle t+1 after accept at t):
  - exact = a + b, zero-extended to WIDTH+1 bits.
  - ed_out = |exact − sum_apx|, computed as an unsigned magnitude in WIDTH+1 bits.
  - ed_valid pulses 1 cycle.
- Stage 2 (t+2):
  - sample_cnt += 1.
  - err_cnt += (ed != 0).
  - max_ed = max(max_ed, ed).
  - sum_ed += ed, saturating at all-ones.
- done rises at t+2 for the final sample. Latency from accept to stats is 2 cycles; throughput is 1 sample/cycle.
- clear with samples in flight: the pipeline is flushed, and in-flight samples neither update stats nor produce ed_valid.
- Counters never wrap, because accept_cnt ≤ window_len ≤ 2^CNT_W−1.
- Asynchronous reset mid-window: everything returns to reset values immediately.

Optional Feature:
- HEAA_REF_MODEL_EN defined: sum_apx is ignored. The block internally forms the HEAA approximate sum from a and b:
  - bits [INACC−2:0] = a|b;
  - bit INACC−1 = (a|b)&~(a&b);
  - the carry into bit INACC is a[INACC−1]&b[INACC−1];
  - bits [WIDTH:INACC] are the exact sum of the upper slices plus that carry.
  - This makes the block a self-contained error-statistics generator.
- Not defined: sum_apx is used as-is. The port exists in both builds.

Decomposition:
- Package heaa_pkg holds:
  - default WIDTH/INACC constants;
  - the FSM state enum (IDLE, RUN, DONE);
  - a function computing the WIDTH+1 absolute difference.
- One combinational sub-module heaa_ref_model(a, b → sum_apx) is instantiated only under HEAA_REF_MODEL_EN.

Test Plan (WIDTH=32, INACC=11):
- a=3, b=1, sum_apx=3 → ed_out=1, one cycle after accept; err_cnt=1; sum_ed=1.
- a=0x400, b=0x400, sum_apx=0x800 → ed_out=0; err_cnt unchanged; sample_cnt increments.
- With HEAA_REF_MODEL_EN: a=0x3FF, b=0x3FF → ed_out=0x3FF; max_ed=0x3FF. Also a=0x3FF, b=1 → ed_out=1.
- window_len=4, in_valid held high → exactly 4 accepts; in_ready drops after the 4th; done=1 two cycles after the last accept; sample_cnt=4.
- clear asserted with start in the same cycle, with 2 samples in flight → state IDLE, all statistics 0, no ed_valid pulses for flushed samples.
- Preload sum_ed near saturation (window of 0xFFFF… ED samples, ACC_W=48) → sum_ed sticks at 2^48−1; rst mid-window → all outputs 0 asynchronously.
